d10_roll_controller: RTL and testbench
======================================

// Module: d10_roll_controller
// PURPOSE
//  Front-end/consumer for the D10 roller: takes a raw push-button, synchronises and debounces it,
//  and issues a 1-cycle roll pulse. It then captures the roller's 5-bit result, range-checks it
//  (1..10) and accumulates a game of NUM_ROLLS rolls. It sits between the board button and the
//  roller block and feeds the display/score logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive synced-stable cycles needed to accept a press or a release (>=1)
//  NUM_ROLLS        3   valid rolls per game (>=1)
//  SUM_W            6   width of total; must hold NUM_ROLLS*10 (default max 30)
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  btn         in   1      raw roll button, asynchronous, active-high, bouncy
//  dicenum_in  in   5      result from roller; updated on the edge that samples roll_out
//  roll_out    out  1      single-cycle roll request to roller
//  last_roll   out  5      last valid captured roll (1..10)
//  total       out  SUM_W  sum of valid rolls in current game
//  roll_count  out  4      valid rolls taken in current game (0..NUM_ROLLS)
//  done        out  1      high while game complete (roll_count==NUM_ROLLS)
//  err         out  1      sticky: an out-of-range value (0 or >10) was captured
// BEHAVIOUR
//  Reset (reset==0, async): all outputs 0, state IDLE, sync flops 0, debounce counter 0.
//  Sync: btn passes 2 flops -> btn_s (2-cycle latency). Debounce counter counts cycles in which
//   btn_s matches the target level; any mismatch clears it to 0.
//  FSM:
//   IDLE     wait btn_s==1 for DEBOUNCE_CYCLES consecutive cycles -> REQ.
//   REQ      roll_out=1 for exactly this cycle -> WAIT.
//   WAIT     1 cycle; dicenum_in is now the new result -> CAPTURE (dicenum_in registered at end of WAIT).
//   CAPTURE  value v in 1..10: last_roll<=v, total<=total+v, roll_count<=roll_count+1.
//            v==0 or v>10: err<=1; last_roll/total/roll_count unchanged.
//            -> RELEASE.
//   RELEASE  wait btn_s==0 for DEBOUNCE_CYCLES consecutive cycles;
//            then -> DONE if roll_count==NUM_ROLLS, else IDLE.
//   DONE     done=1. A debounced press -> clear total, roll_count, last_roll and err,
//            then go to REQ on the following cycle (the press is also the first roll of the new game).
//  Latency: btn rising and held clean -> roll_out high at 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//   roll_out -> outputs updated 2 edges later.
//  Exactly one roll_out per accepted press. Holding btn never re-triggers until a debounced
//   release is seen. Glitches shorter than DEBOUNCE_CYCLES produce no roll.
//  roll_out is never high in two consecutive cycles and never high outside REQ.
//  Arithmetic: total add is unsigned SUM_W bits, no wrap is possible under the parameter rule.
//   roll_count saturates by construction at NUM_ROLLS.
//  Reset mid-operation (any state, including during roll_out): immediate return to the reset
//   values above. roll_out drops asynchronously.
//  btn bouncing during RELEASE restarts the release count; it never issues a roll.
// TESTING
//  1 Reset then clean press (btn=1 held 20 cycles) -> exactly one roll_out pulse at cycle 2+4+1=7
//    after btn rise; dicenum_in=7 -> last_roll=7, total=7, roll_count=1, done=0.
//  2 Bounce: btn toggles 1/0 every 2 cycles for 20 cycles, then stays 0 -> no roll_out, all outputs 0.
//  3 Full game: three clean presses, dicenum_in=10,1,5 -> total=16, roll_count=3, done=1 after
//    release. A 4th press clears total/count and pulses roll_out; with dicenum_in=2 -> total=2, count=1.
//  4 Range check: dicenum_in=0 then 11 on two presses -> err=1, total/roll_count unchanged;
//    next value 4 -> total=4 and err stays 1.
//  5 Hold: btn held high for 100 cycles -> one roll_out only. Release then press -> second pulse.
//  6 Async reset asserted in the REQ cycle -> roll_out low immediately, outputs 0, FSM in IDLE.
//    Pressing after reset deasserts rolls normally.

Source files
------------

// File: rtl/d10_roll_controller.sv
// d10_roll_controller: debounced roll button front-end that requests D10 rolls and scores a game
module d10_roll_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int NUM_ROLLS       = 3,
  parameter int SUM_W           = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic [4:0]       dicenum_in,
  output logic             roll_out,
  output logic [4:0]       last_roll,
  output logic [SUM_W-1:0] total,
  output logic [3:0]       roll_count,
  output logic             done,
  output logic             err
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CAPTURE,
    S_RELEASE,
    S_DONE
  } state_t;
  state_t           r_state, w_next;
  logic             r_sync1, r_sync2;
  logic [CW-1:0]    r_db_cnt, w_db_next;
  logic [4:0]       r_dice, r_last;
  logic [SUM_W-1:0] r_total;
  logic [3:0]       r_count;
  logic             r_done, r_err;
  logic             w_stable, w_target, w_counting, w_valid, w_clear;
  assign w_stable   = r_db_cnt == DB_MAX;
  assign w_target   = r_state != S_RELEASE;
  assign w_counting = r_state == S_IDLE || r_state == S_RELEASE || r_state == S_DONE;
  assign w_valid    = r_dice != 5'd0 && r_dice <= 5'd10;
  assign roll_out   = r_state == S_REQ;
  assign last_roll  = r_last;
  assign total      = r_total;
  assign roll_count = r_count;
  assign done       = r_done;
  assign err        = r_err;
  // next state; a debounced press in DONE also clears the finished game
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE:    w_next = w_stable ? S_REQ : S_IDLE;
      S_REQ:     w_next = S_WAIT;
      S_WAIT:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RELEASE;
      S_RELEASE: w_next = !w_stable ? S_RELEASE : (r_count == 4'(NUM_ROLLS)) ? S_DONE : S_IDLE;
      S_DONE: begin
        w_next  = w_stable ? S_REQ : S_DONE;
        w_clear = w_stable;
      end
      default:   w_next = S_IDLE;
    endcase
  end
  // debounce count of synced cycles at the level the current state waits for; restarts on any change
  always_comb begin
    w_db_next = (!w_counting || w_next != r_state || r_sync2 != w_target) ? '0 :
                w_stable ? r_db_cnt : r_db_cnt + CW'(1);
  end
  // button synchroniser, debounce counter and state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_db_cnt <= '0;
      r_state  <= S_IDLE;
    end else begin
      r_sync1  <= btn;
      r_sync2  <= r_sync1;
      r_db_cnt <= w_db_next;
      r_state  <= w_next;
    end
  end
  // roll capture, range check and game accumulation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dice  <= '0;
      r_last  <= '0;
      r_total <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_next == S_DONE;
      if (r_state == S_WAIT) r_dice <= dicenum_in;
      if (w_clear) begin
        r_last  <= '0;
        r_total <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
        if (w_valid) begin
          r_last  <= r_dice;
          r_total <= r_total + SUM_W'(r_dice);
          r_count <= r_count + 4'd1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_d10_roll_controller.sv
// tb_d10_roll_controller: scoreboard bench for the D10 roll controller
module tb_d10_roll_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn = 1'b0;
  logic [4:0] dicenum_in = '0;
  logic       roll_out;
  logic [4:0] last_roll;
  logic [5:0] total;
  logic [3:0] roll_count;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [4:0] last;
    logic [5:0] total;
    logic [3:0] count;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pulses = 0;

  d10_roll_controller dut (
    .clk(clk), .reset(reset), .btn(btn), .dicenum_in(dicenum_in),
    .roll_out(roll_out), .last_roll(last_roll), .total(total),
    .roll_count(roll_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every roll pulse must be one cycle wide and its capture must match the next scoreboard entry
  initial forever begin
    @(negedge clk);
    if (roll_out) begin
      n_pulses++;
      @(negedge clk);
      chk("roll_out_single_cycle", roll_out, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      if (sb.size() == 0) chk("unexpected_roll", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("last_roll", last_roll, mon_e.last);
        chk("total", total, mon_e.total);
        chk("roll_count", roll_count, mon_e.count);
        chk("err", err, mon_e.err);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    btn = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_roll_out"}, roll_out, 0);
    chk({tag, "_last_roll"}, last_roll, 0);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_roll_count"}, roll_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic press(input logic [4:0] d, input int hold, input logic [4:0] el,
                       input logic [5:0] et, input logic [3:0] ec, input logic ee);
    int lat;
    int p0;
    lat = 0;
    p0 = n_pulses;
    dicenum_in = d;
    sb.push_back('{last: el, total: et, count: ec, err: ee});
    @(posedge clk);
    #1 btn = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(posedge clk);
      #1;
      if (roll_out && lat == 0) lat = i;
    end
    chk("press_latency", lat, 7);
    btn = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pulses_per_press", n_pulses - p0, 1);
  endtask

  initial begin
    int p0;
    #1;
    reset = 1'b0;
    #2;
    check_zero("async_reset");
    do_reset();
    check_zero("reset");
    press(5'd7, 20, 5'd7, 6'd7, 4'd1, 1'b0);
    chk("t1_done", done, 0);

    do_reset();
    p0 = n_pulses;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1;
      repeat (2) @(posedge clk);
      #1 btn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    repeat (15) @(posedge clk);
    #1;
    chk("bounce_no_roll", n_pulses - p0, 0);
    check_zero("bounce");

    do_reset();
    press(5'd10, 20, 5'd10, 6'd10, 4'd1, 1'b0);
    chk("game_done_1", done, 0);
    press(5'd1, 20, 5'd1, 6'd11, 4'd2, 1'b0);
    press(5'd5, 20, 5'd5, 6'd16, 4'd3, 1'b0);
    chk("game_done", done, 1);
    chk("game_total", total, 16);
    press(5'd2, 20, 5'd2, 6'd2, 4'd1, 1'b0);
    chk("new_game_done", done, 0);

    do_reset();
    press(5'd0, 20, 5'd0, 6'd0, 4'd0, 1'b1);
    press(5'd11, 20, 5'd0, 6'd0, 4'd0, 1'b1);
    press(5'd4, 20, 5'd4, 6'd4, 4'd1, 1'b1);

    do_reset();
    press(5'd3, 100, 5'd3, 6'd3, 4'd1, 1'b0);
    press(5'd6, 20, 5'd6, 6'd9, 4'd2, 1'b0);

    do_reset();
    p0 = n_pulses;
    dicenum_in = 5'd9;
    btn = 1'b1;
    for (int i = 0; i < 20 && !roll_out; i++) begin
      @(posedge clk);
      #1;
    end
    chk("t6_roll_seen", roll_out, 1);
    reset = 1'b0;
    #1;
    check_zero("t6_reset");
    repeat (3) @(posedge clk);
    #1 btn = 1'b0;
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("t6_aborted_not_monitored", n_pulses - p0, 0);
    check_zero("t6_after");
    press(5'd8, 20, 5'd8, 6'd8, 4'd1, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
